// File: rtl/mul4_pkg.sv
// Shared types and widths for the shared 4x4 multiplier front-end.
package mul4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } mul4_state_t;

  localparam int MUL_OP_W  = 4;
  localparam int MUL_P_W   = 8;
  localparam int OPS_CNT_W = 16;

endpackage

// File: rtl/mul4_core.sv
// Unsigned 4x4 -> 8 multiplier built as a shift-and-add of partial products.
module mul4_core
  import mul4_pkg::*;
(
  input  logic [MUL_OP_W-1:0] i_a,
  input  logic [MUL_OP_W-1:0] i_b,
  output logic [MUL_P_W-1:0]  o_p
);

  always_comb begin
    o_p = '0;
    for (int k = 0; k < MUL_OP_W; k++) begin
      if (i_b[k]) o_p = o_p + (MUL_P_W'(i_a) << k);
    end
  end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping modulo N_REQ.
module rr_grant #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  function automatic int wrap_add(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[wrap_add(int'(i_ptr), k)]) begin
        o_any                            = 1'b1;
        o_gnt[wrap_add(int'(i_ptr), k)] = 1'b1;
        o_idx                            = IDW'(wrap_add(int'(i_ptr), k));
      end
    end
  end

endmodule

// File: rtl/mul4_arbiter.sv
// Round-robin front-end sharing one mul4_core among N_REQ requesters; one operation every 3 cycles at best.
module mul4_arbiter
  import mul4_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [4*N_REQ-1:0]    req_a,
  input  logic [4*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [MUL_P_W-1:0]    rsp_p,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [OPS_CNT_W-1:0]  ops_done
);

  mul4_state_t           r_state;
  logic [IDW-1:0]        r_ptr;
  logic [MUL_OP_W-1:0]   r_a_p0;
  logic [MUL_OP_W-1:0]   r_b_p0;
  logic [IDW-1:0]        r_id_p0;
  logic [MUL_P_W-1:0]    r_p_p1;
  logic [IDW-1:0]        r_id_p1;
  logic                  r_vld_p1;
  logic                  r_busy;
  logic [OPS_CNT_W-1:0]  r_ops;

  logic [N_REQ-1:0]      w_gnt;
  logic [IDW-1:0]        w_idx;
  logic                  w_any;
  logic                  w_xfer;
  logic [IDW-1:0]        w_ptr_nxt;
  logic [MUL_OP_W-1:0]   w_sel_a;
  logic [MUL_OP_W-1:0]   w_sel_b;
  logic [MUL_P_W-1:0]    w_prod;

  rr_grant #(.N_REQ(N_REQ)) u_grant (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  mul4_core u_core (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .o_p (w_prod)
  );

  assign w_xfer    = (r_state == IDLE) && w_any;
  assign w_ptr_nxt = (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + IDW'(1);
  assign w_sel_a   = req_a[int'(w_idx)*MUL_OP_W +: MUL_OP_W];
  assign w_sel_b   = req_b[int'(w_idx)*MUL_OP_W +: MUL_OP_W];

  // p0: operand capture on the grant edge; held only while the core evaluates them
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_a_p0  <= w_sel_a;
      r_b_p0  <= w_sel_b;
      r_id_p0 <= w_idx;
    end
  end

  // p1: FSM, product/ID result register and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_p_p1   <= '0;
      r_id_p1  <= '0;
      r_vld_p1 <= 1'b0;
      r_busy   <= 1'b0;
      r_ops    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= MUL;
            r_busy  <= 1'b1;
            r_ptr   <= w_ptr_nxt;
          end
        end
        MUL: begin
          r_state  <= RSP;
          r_p_p1   <= w_prod;
          r_id_p1  <= r_id_p0;
          r_vld_p1 <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            r_state  <= IDLE;
            r_vld_p1 <= 1'b0;
            r_busy   <= 1'b0;
            r_ops    <= r_ops + OPS_CNT_W'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_vld_p1 <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign rsp_valid = r_vld_p1;
  assign rsp_id    = r_id_p1;
  assign rsp_p     = r_p_p1;
  assign busy      = r_busy;
  assign ops_done  = r_ops;

endmodule

// File: tb/tb_mul4_arbiter.sv
// Self-checking bench for mul4_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mul4_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_p;
  logic           rsp_ready;
  logic           busy;
  logic [15:0]    ops_done;

  int checks = 0;
  int errors = 0;

  // reference model: pointer, one in-flight op, completion count
  int m_ptr, m_age, m_ops, exp_id, exp_p;
  bit m_busy;
  int gnt_log[$];
  int rsp_log[$];

  mul4_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_age  = 0;
    m_ops  = 0;
    m_busy = 1'b0;
  endtask

  // Checks outputs mid-cycle against the model, then advances the model to the next edge.
  always @(negedge clk) begin : mon
    logic [N-1:0] eg;
    int g;
    if (rst === 1'b0) begin
      eg = '0;
      g  = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
      if (m_busy && m_age >= 1) begin
        chk("rsp_p", 32'(rsp_p), 32'(exp_p));
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
      end
      chk("ops_done", 32'(ops_done), 32'(m_ops));
      if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id) * 256 + int'(rsp_p));
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1;
          m_age  = 0;
          exp_id = g;
          exp_p  = int'(req_a[4*g +: 4]) * int'(req_b[4*g +: 4]);
          m_ptr  = (g + 1) % N;
          gnt_log.push_back(g);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
        m_ops  = (m_ops + 1) % 65536;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [15:0] ea, eb;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_p", 32'(rsp_p), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ops", 32'(ops_done), 32'h0);
    cyc(2);
    rst = 1'b0;

    // single request on requester 2: 15*15
    req_valid = 4'b0100; req_a[11:8] = 4'hF; req_b[11:8] = 4'hF; rsp_ready = 1'b1;
    #1 chk("single_gnt", 32'(req_ready), 32'h4);
    cyc(1);
    req_valid = '0;
    chk("single_mul_vld", 32'(rsp_valid), 32'h0);
    cyc(1);
    chk("single_vld", 32'(rsp_valid), 32'h1);
    chk("single_p", 32'(rsp_p), 32'hE1);
    chk("single_id", 32'(rsp_id), 32'h2);
    cyc(1);
    chk("single_ops", 32'(ops_done), 32'h1);

    // backpressure on requester 1: 6*7 held for 10 cycles with others pending
    n0 = rsp_log.size();
    req_valid = 4'b0010; req_a[7:4] = 4'h6; req_b[7:4] = 4'h7; rsp_ready = 1'b0;
    cyc(1);
    req_valid = 4'hF;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_p", 32'(rsp_p), 32'h2A);
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_gnt", 32'(req_ready), 32'h0);
      cyc(1);
    end
    req_valid = '0; rsp_ready = 1'b1;
    cyc(2);
    chk("bp_one_rsp", 32'(rsp_log.size() - n0), 32'h1);
    chk("bp_ops", 32'(ops_done), 32'h2);

    // reset asserted while holding a 0x2A result
    req_valid = 4'b0001; req_a[3:0] = 4'h6; req_b[3:0] = 4'h7; rsp_ready = 1'b0;
    cyc(1);
    req_valid = '0;
    cyc(1);
    chk("mid_p", 32'(rsp_p), 32'h2A);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_vld", 32'(rsp_valid), 32'h0);
    chk("arst_p", 32'(rsp_p), 32'h0);
    chk("arst_id", 32'(rsp_id), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ops", 32'(ops_done), 32'h0);
    chk("arst_gnt", 32'(req_ready), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_ops", 32'(ops_done), 32'h0);

    // contention: everyone requests, pointer starts at 0
    ea = 16'h8073; eb = 16'h2B95;
    req_a = ea; req_b = eb; rsp_ready = 1'b1;
    gnt_log.delete();
    n0 = rsp_log.size();
    req_valid = 4'hF;
    cyc(15);
    req_valid = '0;
    cyc(3);
    chk("cont_ngnt", 32'(gnt_log.size()), 32'd5);
    chk("cont_nrsp", 32'(rsp_log.size() - n0), 32'd5);
    if (gnt_log.size() >= 5 && rsp_log.size() - n0 >= 5) begin
      chk("cont_g0", 32'(gnt_log[0]), 32'd0);
      chk("cont_g1", 32'(gnt_log[1]), 32'd1);
      chk("cont_g2", 32'(gnt_log[2]), 32'd2);
      chk("cont_g3", 32'(gnt_log[3]), 32'd3);
      chk("cont_g4", 32'(gnt_log[4]), 32'd0);
      chk("cont_r0", 32'(rsp_log[n0]),   32'h000F);
      chk("cont_r1", 32'(rsp_log[n0+1]), 32'h013F);
      chk("cont_r2", 32'(rsp_log[n0+2]), 32'h0200);
      chk("cont_r3", 32'(rsp_log[n0+3]), 32'h0310);
      chk("cont_r4", 32'(rsp_log[n0+4]), 32'h000F);
    end

    // fairness: serve 3, then 0 and 3 both request -> 0 wins
    gnt_log.delete();
    req_valid = 4'b1000;
    cyc(1);
    req_valid = '0;
    cyc(2);
    req_valid = 4'b1001;
    #1 chk("fair_gnt", 32'(req_ready), 32'h1);
    cyc(1);
    req_valid = '0;
    cyc(2);
    chk("fair_n", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("fair_g0", 32'(gnt_log[0]), 32'd3);
      chk("fair_g1", 32'(gnt_log[1]), 32'd0);
    end

    // exhaustive operand sweep on requester 1
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_a[7:4] = 4'(a); req_b[7:4] = 4'(b); req_valid = 4'b0010;
        cyc(1);
        req_valid = '0;
        cyc(1);
        chk("sweep_p", 32'(rsp_p), 32'(a * b));
        cyc(1);
      end
    end

    // counter wrap from 0xFFFF
    force dut.r_ops = 16'hFFFF;
    #1 release dut.r_ops;
    m_ops = 65535;
    chk("wrap_pre", 32'(ops_done), 32'hFFFF);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    cyc(2);
    chk("wrap_post", 32'(ops_done), 32'h0);

    // random traffic
    repeat (400) begin
      req_valid = N'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    req_valid = '0; rsp_ready = 1'b1;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
